exp_vector_sequencer: RTL and testbench

Sequencer for the shared exponent LUT unit in the softmax compute stage. It accepts one vector of up to `vector_len` non-negative fixed-point differences (x_max − x_i) and streams each element through the exp unit, one element per cycle. Each exp result is buffered and added into a running sum. After the last element it publishes the sum, then drains the buffered exp values in order to the normalisation stage.

---
 rtl/exp_vector_sequencer_if.sv | 51 +++++
 rtl/exp_vector_sequencer.sv | 126 ++++++++++++
 tb/tb_exp_vector_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// exp_vector_sequencer_if
// Bundles every non-clock signal of the exponent-LUT sequencer.
//   slave  : seen by the sequencer (control/element inputs, exp-unit result,
//            drain ready in; exp operand, sum, drain data, status out).
//   master : the opposite direction, for whatever drives the sequencer.
// Parameters:
//   DATA_W     element and exp-result width (exp results are 0.DATA_W fraction)
//   VECTOR_LEN maximum elements per vector / buffer depth
//   SUM_W      accumulator width (DATA_W <= SUM_W)
// ---------------------------------------------------------------------------
interface exp_vector_sequencer_if #(
  parameter int DATA_W     = 32,
  parameter int VECTOR_LEN = 16,
  parameter int SUM_W      = 36
);
  localparam int LEN_W = $clog2(VECTOR_LEN) + 1;

  logic              start_i;
  logic [LEN_W-1:0]  length_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] exp_data_o;
  logic              exp_valid_o;
  logic [DATA_W-1:0] exp_result_i;
  logic              exp_result_valid_i;
  logic [SUM_W-1:0]  sum_o;
  logic              sum_valid_o;
  logic              sum_ovf_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              out_last_o;
  logic              busy_o;
  logic              error_o;

  modport slave (
    input  start_i, length_i, in_data_i, in_valid_i,
           exp_result_i, exp_result_valid_i, out_ready_i,
    output in_ready_o, exp_data_o, exp_valid_o, sum_o, sum_valid_o,
           sum_ovf_o, out_data_o, out_valid_o, out_last_o, busy_o, error_o
  );

  modport master (
    output start_i, length_i, in_data_i, in_valid_i,
           exp_result_i, exp_result_valid_i, out_ready_i,
    input  in_ready_o, exp_data_o, exp_valid_o, sum_o, sum_valid_o,
           sum_ovf_o, out_data_o, out_valid_o, out_last_o, busy_o, error_o
  );
endinterface

// File: rtl/exp_vector_sequencer.sv
// ---------------------------------------------------------------------------
// exp_vector_sequencer
// Streams one vector of (x_max - x_i) differences through the shared exp LUT
// unit, one element per cycle, buffers each exp result and accumulates their
// sum. After the last element the sum is published for one cycle (SUM), then
// the buffered exp values are drained in input order.
// Ports:
//   clock_i    sole clock, rising edge
//   reset_n_i  synchronous, active-low reset
//   bus        exp_vector_sequencer_if.slave (start/length, element stream,
//              exp unit operand/result, sum/overflow, drain stream, status)
// Build option:
//   EXP_SEQ_SUM_SAT_EN  defined   -> sum saturates to all-ones, sum_ovf_o sticky
//                       undefined -> sum wraps modulo 2^SUM_W, sum_ovf_o is 0
// ---------------------------------------------------------------------------
module exp_vector_sequencer #(
  parameter int DATA_W     = 32,
  parameter int VECTOR_LEN = 16,
  parameter int SUM_W      = 36
) (
  input logic                    clock_i,
  input logic                    reset_n_i,
  exp_vector_sequencer_if.slave  bus
);
  localparam int LEN_W = $clog2(VECTOR_LEN) + 1;
  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(VECTOR_LEN);

  typedef enum logic [1:0] {IDLE, COMPUTE, SUM, DRAIN} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  wr_ptr_q, rd_ptr_q, last_q;
  logic [SUM_W-1:0]  sum_q;
  logic              ovf_q;
  logic              err_q;
  logic [DATA_W-1:0] buf_q [VECTOR_LEN];

  logic              xfer;
  logic              len_ok;
  logic [SUM_W:0]    acc_d;

  // Returns {overflow, new_sum}. The overflow bit is only ever set when
  // saturation is built in, so the flag register folds to 0 otherwise.
  function automatic logic [SUM_W:0] acc_add(input logic [SUM_W-1:0] sum,
                                             input logic [DATA_W-1:0] res);
    logic [SUM_W:0] wide;
    wide = {1'b0, sum} + {1'b0, SUM_W'(res)};
`ifdef EXP_SEQ_SUM_SAT_EN
    if (wide[SUM_W]) return {1'b1, {SUM_W{1'b1}}};
    return wide;
`else
    return {1'b0, wide[SUM_W-1:0]};
`endif
  endfunction

  // A transfer needs the exp result in the same cycle; in_ready_o already
  // carries exp_result_valid_i so an element without a result is retried.
  assign xfer   = bus.in_valid_i & bus.in_ready_o;
  assign len_ok = (bus.length_i != '0) && (bus.length_i <= MAX_LEN);
  assign acc_d  = acc_add(sum_q, bus.exp_result_i);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (len_ok) begin
              // Latch the index of the final element rather than the count.
              last_q   <= IDX_W'(bus.length_i - LEN_W'(1));
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              sum_q    <= '0;
              ovf_q    <= 1'b0;
              state_q  <= COMPUTE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (xfer) begin
            sum_q <= acc_d[SUM_W-1:0];
            ovf_q <= ovf_q | acc_d[SUM_W];
            if (wr_ptr_q == last_q) state_q <= SUM;
            else                    wr_ptr_q <= wr_ptr_q + 1'b1;
          end
        end
        SUM: state_q <= DRAIN;
        DRAIN: begin
          if (bus.out_ready_i) begin
            if (rd_ptr_q == last_q) state_q <= IDLE;
            else                    rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result buffer: data only, never reset.
  always_ff @(posedge clock_i) begin
    if (reset_n_i && xfer) buf_q[wr_ptr_q] <= bus.exp_result_i;
  end

  assign bus.in_ready_o  = (state_q == COMPUTE) & bus.exp_result_valid_i;
  assign bus.exp_data_o  = (state_q == COMPUTE) ? bus.in_data_i : '0;
  assign bus.exp_valid_o = bus.in_valid_i & bus.in_ready_o;
  assign bus.sum_o       = sum_q;
  assign bus.sum_valid_o = (state_q == SUM);
  assign bus.sum_ovf_o   = ovf_q;
  assign bus.out_valid_o = (state_q == DRAIN);
  assign bus.out_data_o  = (state_q == DRAIN) ? buf_q[rd_ptr_q] : '0;
  assign bus.out_last_o  = (state_q == DRAIN) && (rd_ptr_q == last_q);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.error_o     = err_q;

endmodule

// File: tb/tb_exp_vector_sequencer.sv
module tb_exp_vector_sequencer;
  localparam int DW  = 32;
  localparam int VL  = 16;
  localparam int SW  = 36;
  localparam int SWN = 33;
  localparam int LW  = $clog2(VL) + 1;
`ifdef EXP_SEQ_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_vector_sequencer_if #(.DATA_W(DW), .VECTOR_LEN(VL), .SUM_W(SW))  ifa ();
  exp_vector_sequencer_if #(.DATA_W(DW), .VECTOR_LEN(VL), .SUM_W(SWN)) ifb ();

  exp_vector_sequencer #(.DATA_W(DW), .VECTOR_LEN(VL), .SUM_W(SW)) dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .bus(ifa));
  exp_vector_sequencer #(.DATA_W(DW), .VECTOR_LEN(VL), .SUM_W(SWN)) dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .bus(ifb));

  // Stand-in exp LUT: combinational, 0 maps to 0xFFFFFFFF.
  assign ifa.exp_result_i = ~ifa.exp_data_o;
  assign ifb.exp_result_i = ~ifb.exp_data_o;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] din [VL];

  task automatic clear_inputs();
    ifa.start_i = 0; ifa.length_i = '0; ifa.in_data_i = '0; ifa.in_valid_i = 0;
    ifa.exp_result_valid_i = 0; ifa.out_ready_i = 0;
    ifb.start_i = 0; ifb.length_i = '0; ifb.in_data_i = '0; ifb.in_valid_i = 0;
    ifb.exp_result_valid_i = 0; ifb.out_ready_i = 0;
  endtask

  // Runs one full vector on dut_a, checking against a queue/arithmetic model.
  // vmode: 0 no stalls, 1 in_valid toggles + random result valid, 2 random
  // rmode: 0 out_ready high, 1 alternate, 2 random
  task automatic run_vector(input int n, input int vmode, input int rmode,
                            input bit start_in_drain, input bit check_lat);
    logic [DW-1:0] expq[$];
    logic [63:0] acc, modulus;
    logic [DW-1:0] e, held;
    logic [SW-1:0] es;
    bit ovf, prev_stall;
    int idx, got, guard, cyc, busy_cyc;
    acc = 0; ovf = 0; modulus = 64'd1 << SW;
    for (int i = 0; i < n; i++) begin
      e = ~din[i];
      expq.push_back(e);
      acc = acc + {32'd0, e};
      if (acc >= modulus) begin
        if (SAT) begin acc = modulus - 1; ovf = 1; end
        else acc = acc % modulus;
      end
    end
    es = acc[SW-1:0];

    @(negedge clk);
    ifa.start_i = 1; ifa.length_i = LW'(n);
    @(negedge clk);
    ifa.start_i = 0;

    idx = 0; guard = 0; cyc = 0; busy_cyc = 0;
    while (idx < n && guard < 4000) begin
      ifa.in_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ifa.in_data_i  = din[idx];
      ifa.exp_result_valid_i = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (ifa.busy_o) busy_cyc++;
      vectors++;
      if (ifa.in_ready_o !== ifa.exp_result_valid_i) begin
        miscompares++;
        $display("FAIL in_ready: got %b required %b (elem %0d)", ifa.in_ready_o, ifa.exp_result_valid_i, idx);
      end
      if (ifa.in_valid_i && ifa.exp_result_valid_i) begin
        vectors++;
        if (ifa.exp_data_o !== din[idx] || ifa.exp_valid_o !== 1'b1) begin
          miscompares++;
          $display("FAIL exp_operand: got %h/%b required %h/1", ifa.exp_data_o, ifa.exp_valid_o, din[idx]);
        end
        idx++;
      end
      cyc++; guard++;
      @(negedge clk);
    end
    if (guard >= 4000) begin
      miscompares++;
      $display("FAIL compute_timeout: got %0d elements required %0d", idx, n);
    end
    ifa.in_valid_i = 0;

    #1;
    if (ifa.busy_o) busy_cyc++;
    vectors++;
    if (ifa.sum_valid_o !== 1'b1 || ifa.sum_o !== es || ifa.sum_ovf_o !== ovf || ifa.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL sum: got vld=%b sum=%h ovf=%b required vld=1 sum=%h ovf=%b", ifa.sum_valid_o, ifa.sum_o, ifa.sum_ovf_o, es, ovf);
    end
    @(negedge clk);

    got = 0; guard = 0; prev_stall = 0; held = '0;
    while (got < n && guard < 4000) begin
      ifa.out_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      ifa.start_i  = start_in_drain && (got != n - 1);
      ifa.length_i = LW'(3);
      #1;
      if (ifa.busy_o) busy_cyc++;
      vectors++;
      if (ifa.out_valid_o !== 1'b1 || ifa.sum_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_valid: got out_valid=%b sum_valid=%b required 1/0", ifa.out_valid_o, ifa.sum_valid_o);
      end
      if (prev_stall) begin
        vectors++;
        if (ifa.out_data_o !== held) begin
          miscompares++;
          $display("FAIL drain_stable: got %h required %h", ifa.out_data_o, held);
        end
      end
      if (ifa.out_ready_i) begin
        vectors++;
        if (ifa.out_data_o !== expq[got] || ifa.out_last_o !== (got == n - 1)) begin
          miscompares++;
          $display("FAIL drain_data[%0d]: got %h last=%b required %h last=%b", got, ifa.out_data_o, ifa.out_last_o, expq[got], (got == n - 1));
        end
        got++; prev_stall = 0;
      end else begin
        prev_stall = 1; held = ifa.out_data_o;
      end
      cyc++; guard++;
      @(negedge clk);
    end
    if (guard >= 4000) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d elements required %0d", got, n);
    end
    ifa.out_ready_i = 0; ifa.start_i = 0;

    #1;
    vectors++;
    if (ifa.busy_o !== 1'b0 || ifa.out_valid_o !== 1'b0 || ifa.sum_o !== es) begin
      miscompares++;
      $display("FAIL end_idle: got busy=%b out_valid=%b sum=%h required 0/0/%h", ifa.busy_o, ifa.out_valid_o, ifa.sum_o, es);
    end
    if (check_lat) begin
      vectors++;
      if (busy_cyc !== 2 * n + 1) begin
        miscompares++;
        $display("FAIL latency: got %0d busy cycles required %0d", busy_cyc, 2 * n + 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (ifa.in_ready_o !== 0 || ifa.exp_valid_o !== 0 || ifa.sum_valid_o !== 0 ||
        ifa.sum_ovf_o !== 0 || ifa.out_valid_o !== 0 || ifa.out_last_o !== 0 ||
        ifa.busy_o !== 0 || ifa.error_o !== 0) begin
      miscompares++;
      $display("FAIL %s_flags: got rdy=%b ev=%b sv=%b ovf=%b ov=%b last=%b busy=%b err=%b required all 0", tag,
               ifa.in_ready_o, ifa.exp_valid_o, ifa.sum_valid_o, ifa.sum_ovf_o, ifa.out_valid_o, ifa.out_last_o, ifa.busy_o, ifa.error_o);
    end
    vectors++;
    if (ifa.sum_o !== '0 || ifa.exp_data_o !== '0 || ifa.out_data_o !== '0) begin
      miscompares++;
      $display("FAIL %s_data: got sum=%h exp=%h out=%h required 0", tag, ifa.sum_o, ifa.exp_data_o, ifa.out_data_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    ifa.in_valid_i = 1; ifa.in_data_i = $urandom() | 32'h1; ifa.exp_result_valid_i = 1; ifa.out_ready_i = 1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 4; i++) din[i] = '0;
    run_vector(4, 0, 0, 0, 1);
    vectors++;
    if (ifa.sum_o !== 36'h3FFFFFFFC) begin
      miscompares++;
      $display("FAIL zero_sum: got %h required 3fffffffc", ifa.sum_o);
    end
  endtask

  task automatic test_stall_16();
    for (int i = 0; i < VL; i++) din[i] = $urandom();
    run_vector(16, 1, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, VL);
      for (int i = 0; i < n; i++) din[i] = $urandom();
      run_vector(n, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    end
  endtask

  task automatic test_illegal_len();
    int lens [2];
    lens[0] = 0; lens[1] = 17;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ifa.start_i = 1; ifa.length_i = LW'(lens[k]);
      @(negedge clk);
      ifa.start_i = 0;
      #1;
      vectors++;
      if (ifa.error_o !== 1'b1 || ifa.busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_len%0d: got err=%b busy=%b required 1/0", lens[k], ifa.error_o, ifa.busy_o);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (ifa.error_o !== 1'b0 || ifa.busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_pulse%0d: got err=%b busy=%b required 0/0", lens[k], ifa.error_o, ifa.busy_o);
      end
    end
    din[0] = $urandom();
    run_vector(1, 0, 0, 0, 1);
  endtask

  task automatic test_narrow_sat();
    logic [SWN-1:0] exp_sum;
    int guard, got;
    exp_sum = SAT ? 33'h1FFFFFFFF : 33'h0FFFFFFFD;
    @(negedge clk);
    ifb.start_i = 1; ifb.length_i = LW'(3);
    @(negedge clk);
    ifb.start_i = 0;
    for (int k = 0; k < 3; k++) begin
      ifb.in_valid_i = 1; ifb.in_data_i = '0; ifb.exp_result_valid_i = 1;
      @(negedge clk);
    end
    ifb.in_valid_i = 0;
    #1;
    vectors++;
    if (ifb.sum_valid_o !== 1'b1 || ifb.sum_o !== exp_sum || ifb.sum_ovf_o !== SAT) begin
      miscompares++;
      $display("FAIL narrow_sum: got vld=%b sum=%h ovf=%b required 1/%h/%b", ifb.sum_valid_o, ifb.sum_o, ifb.sum_ovf_o, exp_sum, SAT);
    end
    ifb.out_ready_i = 1;
    guard = 0; got = 0;
    while (ifb.busy_o && guard < 100) begin
      @(negedge clk); #1;
      if (ifb.out_valid_o) begin
        vectors++; got++;
        if (ifb.out_data_o !== 32'hFFFFFFFF) begin
          miscompares++;
          $display("FAIL narrow_drain: got %h required ffffffff", ifb.out_data_o);
        end
      end
      guard++;
    end
    vectors++;
    if (got !== 3 || ifb.sum_ovf_o !== SAT) begin
      miscompares++;
      $display("FAIL narrow_end: got %0d drained ovf=%b required 3/%b", got, ifb.sum_ovf_o, SAT);
    end
    ifb.out_ready_i = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) din[i] = $urandom();
    @(negedge clk);
    ifa.start_i = 1; ifa.length_i = LW'(8);
    @(negedge clk);
    ifa.start_i = 0;
    for (int k = 0; k < 5; k++) begin
      ifa.in_valid_i = 1; ifa.in_data_i = din[k]; ifa.exp_result_valid_i = 1;
      @(negedge clk);
    end
    ifa.in_valid_i = 0;
    rst_n = 0;
    @(negedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst_n = 1;
    for (int i = 0; i < 2; i++) din[i] = $urandom();
    run_vector(2, 0, 0, 0, 1);
  endtask

  task automatic test_start_in_drain();
    for (int i = 0; i < 5; i++) din[i] = $urandom();
    run_vector(5, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) din[i] = $urandom();
    run_vector(3, 0, 0, 0, 1);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_all_zero();
    test_stall_16();
    test_random();
    test_illegal_len();
    test_narrow_sat();
    test_reset_mid();
    test_start_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
